// File: rtl/data_mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port data memory.
// Each transaction is IDLE -> ACCESS -> ACK. Operands are latched at grant.
// Outputs are registered, and there is never a back-to-back grant.
module data_mem_arbiter #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              rw0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  input  logic              req1,
  input  logic              rw1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              read_write,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_out_memory,
  input  logic [DATA_W-1:0] data_in_memory,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StAccess, StAck} state_e;

  state_e              r_state;
  logic                r_owner;       // requester of the transaction in flight
  logic                r_last;        // requester served last; the other one wins a tie
  logic                r_rw;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_read_write;
  logic                r_ack0;
  logic                r_ack1;
  logic                r_busy;

  logic                w_pending;
  logic                w_pick;
  logic                w_rw;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_wdata;

  // Grant decision: a lone request always wins, a tie goes to the one not served last.
  always_comb begin
    w_pending = req0 | req1;
    if (req0 && req1) begin
      w_pick = ~r_last;
    end else begin
      w_pick = req1;
    end
    w_rw    = w_pick ? rw1    : rw0;
    w_addr  = w_pick ? addr1  : addr0;
    w_wdata = w_pick ? wdata1 : wdata0;
  end

  // Transaction sequencer with registered memory-side and requester-side outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= StIdle;
      r_owner      <= 1'b0;
      r_last       <= 1'b1;
      r_rw         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
      r_read_write <= 1'b0;
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_pending) begin
            r_state      <= StAccess;
            r_busy       <= 1'b1;
            r_owner      <= w_pick;
            r_rw         <= w_rw;
            r_addr       <= w_addr;
            r_wdata      <= w_wdata;
            r_read_write <= w_rw;
          end
        end
        StAccess: begin
          r_state      <= StAck;
          r_read_write <= 1'b0;
          if (!r_rw) begin
            r_rdata <= data_in_memory;
          end
          r_ack0 <= ~r_owner;
          r_ack1 <= r_owner;
          r_last <= r_owner;
        end
        StAck: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
          r_ack0  <= 1'b0;
          r_ack1  <= 1'b0;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign ack0            = r_ack0;
  assign ack1            = r_ack1;
  assign rdata           = r_rdata;
  assign read_write      = r_read_write;
  assign addr            = r_addr;
  assign data_out_memory = r_wdata;
  assign busy            = r_busy;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed scenarios followed by random traffic.
// A transaction-level model checks the DUT on every cycle.
module tb_data_mem_arbiter;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, rw0, req1, rw1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1, read_write, busy;
  logic [AW-1:0] addr;
  logic [DW-1:0] rdata, data_out_memory, data_in_memory;

  logic [DW-1:0] mem [256];

  data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk             (clk),
    .reset           (reset),
    .req0            (req0),
    .rw0             (rw0),
    .addr0           (addr0),
    .wdata0          (wdata0),
    .ack0            (ack0),
    .req1            (req1),
    .rw1             (rw1),
    .addr1           (addr1),
    .wdata1          (wdata1),
    .ack1            (ack1),
    .rdata           (rdata),
    .read_write      (read_write),
    .addr            (addr),
    .data_out_memory (data_out_memory),
    .data_in_memory  (data_in_memory),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  // Memory: combinational read, write on the rising edge while the strobe is high.
  assign data_in_memory = mem[addr];
  always @(posedge clk) if (read_write) mem[addr] <= data_out_memory;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    else n_pass++;
  endtask

  // Transaction-level model: a grant at edge g gives memory access after g, ack after g+1,
  // and the arbiter is free again after g+2.
  int            e    = 0;
  int            m_g  = 0;
  int            k;
  bit            m_txn = 1'b0;
  bit            m_last = 1'b1;
  bit            m_owner, m_rw;
  logic [AW-1:0] m_addr  = '0;
  logic [DW-1:0] m_dout  = '0;
  logic [DW-1:0] m_rdata = '0;
  logic [DW-1:0] m_rval;
  logic [DW-1:0] ref_mem [256];

  task automatic step();
    bit own;
    if (reset) begin
      m_txn = 1'b0; m_last = 1'b1; m_addr = '0; m_dout = '0; m_rdata = '0;
    end else if (!m_txn && (req0 || req1)) begin
      own     = (req0 && req1) ? !m_last : req1;
      m_txn   = 1'b1;
      m_g     = e + 1;
      m_owner = own;
      m_last  = own;
      m_rw    = own ? rw1 : rw0;
      m_addr  = own ? addr1 : addr0;
      m_dout  = own ? wdata1 : wdata0;
      if (m_rw) ref_mem[m_addr] = m_dout;
      else m_rval = ref_mem[m_addr];
    end
    @(posedge clk);
    #1;
    e++;
    k = e - m_g;
    if (m_txn && k == 1 && !m_rw) m_rdata = m_rval;
    check_eq("busy",       32'(busy),       32'(m_txn && k <= 1));
    check_eq("read_write", 32'(read_write), 32'(m_txn && k == 0 && m_rw));
    check_eq("ack0",       32'(ack0),       32'(m_txn && k == 1 && !m_owner));
    check_eq("ack1",       32'(ack1),       32'(m_txn && k == 1 && m_owner));
    check_eq("addr",       32'(addr),       32'(m_addr));
    check_eq("dout",       32'(data_out_memory), 32'(m_dout));
    check_eq("rdata",      32'(rdata),      32'(m_rdata));
    if (m_txn && k >= 2) m_txn = 1'b0;
  endtask

  // One request from a single requester, held until its ack, then released.
  task automatic run_txn(input bit who, input bit rw, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, output logic [DW-1:0] rd);
    bit got = 1'b0;
    int lat = -1;
    rd = '0;
    if (who) begin req1 = 1'b1; rw1 = rw; addr1 = a; wdata1 = d; end
    else     begin req0 = 1'b1; rw0 = rw; addr0 = a; wdata0 = d; end
    for (int i = 0; i < 8 && !got; i++) begin
      step();
      if (who ? ack1 : ack0) begin
        got = 1'b1;
        lat = i;
        rd  = rdata;
        check_eq("other_ack_quiet", 32'(who ? ack0 : ack1), 32'd0);
      end
    end
    check_eq("txn_acked", 32'(got), 32'd1);
    check_eq("ack_latency", 32'(lat), 32'd1);
    if (who) req1 = 1'b0; else req0 = 1'b0;
    step();
  endtask

  function automatic logic [AW-1:0] pick_addr();
    if ($urandom_range(0, 3) == 0) return ($urandom_range(0, 1) == 0) ? 8'hFF : 8'h00;
    return AW'($urandom_range(0, 7));
  endfunction

  initial begin
    logic [DW-1:0] rd;
    int            order [$];
    int            cnt;
    for (int i = 0; i < 256; i++) ref_mem[i] = 'x;
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; rw0 = 1'b0; rw1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    step(); step();
    reset = 1'b0;
    step();

    // Single write, then read-back by the other requester.
    run_txn(1'b0, 1'b1, 8'h10, 16'hBEEF, rd);
    check_eq("mem_10", 32'(mem[8'h10]), 32'hBEEF);
    run_txn(1'b1, 1'b0, 8'h10, 16'h0000, rd);
    check_eq("readback_10", 32'(rd), 32'hBEEF);

    // Simultaneous held requests after reset alternate starting with requester 0.
    reset = 1'b1; step(); reset = 1'b0;
    req0 = 1'b1; rw0 = 1'b1; addr0 = 8'h01; wdata0 = 16'h1111;
    req1 = 1'b1; rw1 = 1'b1; addr1 = 8'h02; wdata1 = 16'h2222;
    for (int i = 0; i < 12; i++) begin
      step();
      if (ack0) order.push_back(0);
      if (ack1) order.push_back(1);
    end
    check_eq("rr_count", 32'(order.size()), 32'd4);
    for (int i = 0; i < order.size() && i < 4; i++) check_eq("rr_order", 32'(order[i]), 32'(i % 2));
    req0 = 1'b0; req1 = 1'b0;
    step(); step(); step();

    // Request dropped during ACCESS still gets exactly one ack.
    req0 = 1'b1; rw0 = 1'b0; addr0 = 8'h03;
    step();
    req0 = 1'b0;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (ack0) cnt++;
    end
    check_eq("abort_ack_once", 32'(cnt), 32'd1);

    // Reset during a write ACCESS drops it and restores the pointer to requester 0.
    req0 = 1'b1; rw0 = 1'b1; addr0 = 8'h33; wdata0 = 16'hAAAA;
    step();
    check_eq("pre_reset_rw", 32'(read_write), 32'd1);
    reset = 1'b1; req0 = 1'b0;
    step();
    reset = 1'b0;
    check_eq("rst_rw", 32'(read_write), 32'd0);
    check_eq("rst_addr", 32'(addr), 32'd0);
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (ack0 || ack1) cnt++;
    end
    check_eq("rst_no_ack", 32'(cnt), 32'd0);
    req0 = 1'b1; rw0 = 1'b0; addr0 = 8'h10;
    req1 = 1'b1; rw1 = 1'b0; addr1 = 8'h10;
    cnt = -1;
    for (int i = 0; i < 4 && cnt < 0; i++) begin
      step();
      if (ack0) cnt = 0;
      else if (ack1) cnt = 1;
    end
    check_eq("rst_ptr_first", 32'(cnt), 32'd0);
    req0 = 1'b0; req1 = 1'b0;
    step(); step();

    // Address extremes do not alias.
    run_txn(1'b0, 1'b1, 8'hFF, 16'h1234, rd);
    run_txn(1'b1, 1'b1, 8'h00, 16'h5678, rd);
    run_txn(1'b0, 1'b0, 8'hFF, 16'h0000, rd);
    check_eq("read_ff", 32'(rd), 32'h1234);
    run_txn(1'b1, 1'b0, 8'h00, 16'h0000, rd);
    check_eq("read_00", 32'(rd), 32'h5678);

    // Random traffic with occasional resets and operand changes while waiting.
    for (int c = 0; c < 1500; c++) begin
      reset = ($urandom_range(0, 99) == 0);
      if (req0 && ack0) req0 = 1'b0;
      else if (!req0 && $urandom_range(0, 2) == 0) begin
        req0 = 1'b1; rw0 = 1'($urandom_range(0, 1)); addr0 = pick_addr(); wdata0 = DW'($urandom);
      end else if (req0 && $urandom_range(0, 7) == 0) begin
        addr0 = pick_addr(); wdata0 = DW'($urandom);
      end
      if (req1 && ack1) req1 = 1'b0;
      else if (!req1 && $urandom_range(0, 2) == 0) begin
        req1 = 1'b1; rw1 = 1'($urandom_range(0, 1)); addr1 = pick_addr(); wdata1 = DW'($urandom);
      end else if (req1 && $urandom_range(0, 7) == 0) begin
        addr1 = pick_addr(); wdata1 = DW'($urandom);
      end
      step();
    end
    reset = 1'b0; req0 = 1'b0; req1 = 1'b0;
    step(); step(); step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, SHALL set the data-memory address width.
REQ-002 Parameter DATA_W, default 16, SHALL set the data-memory word width.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port req0, input, 1: requester 0 (CPU) access request.
REQ-007 Port rw0, input, 1: requester 0 direction (1 = write, 0 = read).
REQ-008 Port addr0, input, ADDR_W: requester 0 address.
REQ-009 Port wdata0, input, DATA_W: requester 0 write data.
REQ-010 Port ack0, output, 1: one-cycle completion strobe to requester 0.
REQ-011 Ports req1, rw1, addr1, wdata1, ack1: identical set for requester 1 (loader/DMA).
REQ-012 Port rdata, output, DATA_W: read data, valid while ack0 or ack1 is high.
REQ-013 Port read_write, output, 1: memory write strobe (1 = write).
REQ-014 Port addr, output, ADDR_W: memory address.
REQ-015 Port data_out_memory, output, DATA_W: memory write data.
REQ-016 Port data_in_memory, input, DATA_W: memory read data; combinational from addr.
REQ-017 Port busy, output, 1: high in any state other than IDLE.

Function
REQ-018 The FSM SHALL have three states: IDLE, ACCESS and ACK.
REQ-019 In IDLE with no request pending, the FSM SHALL stay in IDLE with all memory outputs held.
REQ-020 In IDLE with a request pending, the FSM SHALL select an owner and go to ACCESS on the next edge.
REQ-021 On that same edge, the block SHALL latch the owner's rw, addr and wdata into internal registers.
REQ-022 Owner selection SHALL be round-robin: with both requests high, the requester not served last wins.
REQ-023 With one request high, that requester SHALL win regardless of the priority pointer.
REQ-024 In ACCESS, addr and data_out_memory SHALL carry the latched values.
REQ-025 In ACCESS, read_write SHALL equal the latched rw; read_write SHALL be 0 in every other state.
REQ-026 At the end of ACCESS, the block SHALL register data_in_memory into rdata on reads, hold rdata unchanged on writes, and go to ACK.
REQ-027 In ACK, the owner's ack SHALL be 1 for exactly one cycle, the other ack SHALL be 0, and the priority pointer SHALL update to the owner.
REQ-028 ACK SHALL always return to IDLE.
REQ-029 Each transaction SHALL take exactly 3 cycles from the request being sampled in IDLE to ack; there SHALL be no back-to-back grant.
REQ-030 A requester SHALL hold req and its operands until ack; operand changes after latching SHALL have no effect.
REQ-031 Deasserting req during ACCESS or ACK SHALL NOT abort the transaction; ack is still issued.
REQ-032 A req sampled high in IDLE SHALL be treated as a new request.
REQ-033 The loser of a simultaneous request SHALL be served on the next grant, so no requester waits more than one foreign transaction.
REQ-034 addr and data_out_memory SHALL hold their last values in IDLE and ACK, and read_write SHALL be 0 in both.

Reset
REQ-035 When reset is high at a rising edge, the block SHALL enter IDLE.
REQ-036 Reset SHALL clear ack0, ack1, read_write, busy, addr, data_out_memory, rdata and the latched operands to 0.
REQ-037 Reset SHALL set the priority pointer to favour requester 0.
REQ-038 Reset asserted during ACCESS SHALL override the state: read_write is 0 from the next cycle, no ack is issued, and the transaction is dropped.
REQ-039 Reset SHALL take priority over all requests in the same cycle.

Verification
REQ-040 The bench SHALL cover a single write: req0=1, rw0=1, addr0=0x10, wdata0=0xBEEF -> read_write=1 and addr=0x10 for one cycle, ack0 two cycles after grant, memory[0x10]=0xBEEF.
REQ-041 The bench SHALL cover read-back: req1=1, rw1=0, addr1=0x10 -> ack1=1 with rdata=0xBEEF, ack0 stays 0.
REQ-042 The bench SHALL cover a simultaneous request after reset: req0 and req1 high -> requester 0 served first; both held -> requester 1 served next, then 0 again (alternation over 4 transactions).
REQ-043 The bench SHALL cover an abort: req0 dropped during ACCESS -> ack0 still pulses once, and no second transaction occurs.
REQ-044 The bench SHALL cover reset mid-ACCESS on a write: reset during ACCESS -> state IDLE, no ack, read_write=0, outputs 0, pointer favours requester 0.
REQ-045 The bench SHALL cover address boundaries: write 0x1234 to addr 0xFF and 0x5678 to 0x00, then read both -> rdata 0x1234 and 0x5678 respectively, with no aliasing.
